// File: rtl/spi_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// spi_mem_responder_pkg
//   Shared SPI memory-bus definitions. The mem_bus initiator imports the same
//   command constants, so both ends of the bus agree on the opcode values.
//   Contents: SPI command opcodes and the responder state type.
// ----------------------------------------------------------------------------
package spi_mem_responder_pkg;

   localparam logic [7:0] SPI_CMD_READ  = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_IGNORE
   } spi_resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// ----------------------------------------------------------------------------
// spi_edge_sync
//   Two-flop synchronizer for one asynchronous input, with single-cycle
//   rise/fall pulses derived from the synchronized level.
//   Ports:
//     clk, rst_n : system clock, synchronous active-low reset
//     din        : asynchronous input
//     sync       : synchronized level
//     rise, fall : one-clk pulses on synchronized 0->1 / 1->0 transitions
// ----------------------------------------------------------------------------
module spi_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // All stages clear to 0. For cs_n this means a line already held low
   // through reset never produces a fall, so a frame in progress at reset
   // is not picked up mid-way; an idle-high line only yields a harmless rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// ----------------------------------------------------------------------------
// spi_mem_responder
//   SPI mode-0 memory target serving READ (0x03) and WRITE (0x02) with a
//   24-bit address from an internal 2**ADDR_BITS byte array. Oversamples
//   sclk in the clk domain (clk >= 4x sclk).
//   Parameters:
//     ADDR_BITS : internal address width
//     READ_ONLY : 1 = WRITE is decoded but never modifies memory
//   Ports:
//     clk, rst_n           : system clock, synchronous active-low reset
//     sclk, cs_n, mosi     : SPI inputs from initiator (asynchronous)
//     miso, miso_oe        : serial read data and its drive enable
//     busy                 : high from cs_n fall until return to idle
//     load_en/addr/data    : backdoor byte preload
// ----------------------------------------------------------------------------
module spi_mem_responder
   import spi_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 8,
   parameter bit          READ_ONLY = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sclk,
   input  logic                 cs_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   output logic                 busy,
   input  logic                 load_en,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [7:0]           load_data
);

   localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_edge_sync u_sclk_sync (
      .clk (clk), .rst_n (rst_n), .din (sclk),
      .sync (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
   );

   spi_edge_sync u_cs_sync (
      .clk (clk), .rst_n (rst_n), .din (cs_n),
      .sync (cs_lvl), .rise (cs_rise), .fall (cs_fall)
   );

   spi_edge_sync u_mosi_sync (
      .clk (clk), .rst_n (rst_n), .din (mosi),
      .sync (mosi_s), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
   );

   // sclk activity only counts while the chip is selected
   logic sck_rise, sck_fall;
   assign sck_rise = sclk_rise & ~cs_lvl;
   assign sck_fall = sclk_fall & ~cs_lvl;

   spi_resp_state_t        state_q, state_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [2:0]             fall_cnt_q, fall_cnt_d;
   logic [23:0]            rx_q, rx_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [7:0]             tx_q, tx_d;
   logic                   miso_q, miso_d;
   logic                   is_read_q, is_read_d;

   logic [7:0]             mem [2**ADDR_BITS];
   logic [ADDR_BITS-1:0]   rd_addr;
   logic [7:0]             rd_data;
   logic                   wr_en;
   logic [7:0]             wr_data;
   logic [23:0]            rx_full;
   logic                   rx_top_unused;

   // rx_full is the shift register including the bit arriving this cycle
   assign rx_full       = {rx_q[22:0], mosi_s};
   assign rx_top_unused = rx_q[23];

   // Address phase reads the freshly shifted address so the first byte is
   // in tx the same cycle the address completes; otherwise prefetch addr+1.
   always_comb begin
      rd_addr = addr_q + ADDR_ONE;
      if (state_q == ST_ADDR) begin
         rd_addr = rx_full[ADDR_BITS-1:0];
      end
   end

   assign rd_data = mem[rd_addr];

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      fall_cnt_d = fall_cnt_q;
      rx_d       = rx_q;
      addr_d     = addr_q;
      tx_d       = tx_q;
      miso_d     = miso_q;
      is_read_d  = is_read_q;
      wr_en      = 1'b0;
      wr_data    = rx_full[7:0];

      if (cs_rise) begin
         // deselect aborts any state; partial write bytes are dropped
         state_d    = ST_IDLE;
         miso_d     = 1'b0;
         bit_cnt_d  = '0;
         fall_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = '0;
                  miso_d    = 1'b0;
               end
            end
            ST_CMD: begin
               if (sck_rise) begin
                  rx_d      = rx_full;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     if (rx_full[7:0] == SPI_CMD_READ || rx_full[7:0] == SPI_CMD_WRITE) begin
                        state_d   = ST_ADDR;
                        is_read_d = (rx_full[7:0] == SPI_CMD_READ);
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_ADDR: begin
               if (sck_rise) begin
                  rx_d      = rx_full;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d  = '0;
                     fall_cnt_d = '0;
                     addr_d     = rx_full[ADDR_BITS-1:0];
                     if (is_read_q) begin
                        tx_d    = rd_data;
                        state_d = ST_RD_DATA;
                     end else begin
                        state_d = ST_WR_DATA;
                     end
                  end
               end
            end
            ST_RD_DATA: begin
               if (sck_fall) begin
                  miso_d     = tx_q[7];
                  fall_cnt_d = fall_cnt_q + 3'd1;
                  if (fall_cnt_q == 3'd7) begin
                     addr_d = addr_q + ADDR_ONE;
                     tx_d   = rd_data;
                  end else begin
                     tx_d = {tx_q[6:0], 1'b0};
                  end
               end
            end
            ST_WR_DATA: begin
               if (sck_rise) begin
                  rx_d      = rx_full;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     bit_cnt_d = '0;
                     wr_en     = !READ_ONLY;
                     addr_d    = addr_q + ADDR_ONE;
                  end
               end
            end
            ST_IGNORE: begin
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         fall_cnt_q <= '0;
         rx_q       <= '0;
         addr_q     <= '0;
         tx_q       <= '0;
         miso_q     <= 1'b0;
         is_read_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         fall_cnt_q <= fall_cnt_d;
         rx_q       <= rx_d;
         addr_q     <= addr_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         is_read_q  <= is_read_d;
      end
   end

   // Single write port: an SPI commit takes priority over a backdoor load
   // issued in the same cycle.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr_q] <= wr_data;
      end else if (load_en) begin
         mem[load_addr] <= load_data;
      end
   end

   assign miso    = miso_q;
   assign miso_oe = (state_q == ST_RD_DATA);
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_spi_mem_responder
//   Two responders on a shared SPI bus with separate chip selects: u_ram
//   (read/write) and u_flash (READ_ONLY). Stimulus pushes expected read bytes
//   into a queue; a monitor on sclk rises assembles miso bytes while miso_oe
//   is high and compares them against the queue.
// ----------------------------------------------------------------------------
module tb_spi_mem_responder;

   localparam int HALF = 60;   // sclk half period: 6 clk periods

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n, rst1_n;
   logic       sclk, cs0_n, cs1_n, mosi;
   logic       load_en0, load_en1;
   logic [7:0] load_addr, load_data;
   logic       miso0, miso_oe0, busy0;
   logic       miso1, miso_oe1, busy1;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic       sel;        // 0 selects u_ram, 1 selects u_flash

   spi_mem_responder #(.ADDR_BITS(8), .READ_ONLY(1'b0)) u_ram (
      .clk (clk), .rst_n (rst0_n), .sclk (sclk), .cs_n (cs0_n), .mosi (mosi),
      .miso (miso0), .miso_oe (miso_oe0), .busy (busy0),
      .load_en (load_en0), .load_addr (load_addr), .load_data (load_data)
   );

   spi_mem_responder #(.ADDR_BITS(8), .READ_ONLY(1'b1)) u_flash (
      .clk (clk), .rst_n (rst1_n), .sclk (sclk), .cs_n (cs1_n), .mosi (mosi),
      .miso (miso1), .miso_oe (miso_oe1), .busy (busy1),
      .load_en (load_en1), .load_addr (load_addr), .load_data (load_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic       cur_miso, cur_oe;
   logic [7:0] mon_sh = '0;
   int         mon_bits = 0;
   int         oe_rises = 0;

   assign cur_miso = sel ? miso1 : miso0;
   assign cur_oe   = sel ? miso_oe1 : miso_oe0;

   always @(posedge sclk) begin
      if (cur_oe) begin
         oe_rises++;
         mon_sh = {mon_sh[6:0], cur_miso};
         mon_bits++;
         if (mon_bits == 8) begin
            mon_bits = 0;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rd_unexpected: got byte %0h expected none", mon_sh);
            end else begin
               check("rd_byte", mon_sh, exp_q.pop_front());
            end
         end
      end
   end

   always @(posedge cs0_n or posedge cs1_n) mon_bits = 0;

   // ---------------- stimulus helpers ----------------
   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      load_addr = a;
      load_data = d;
      if (sel) load_en1 = 1'b1; else load_en0 = 1'b1;
      @(negedge clk);
      load_en0 = 1'b0;
      load_en1 = 1'b0;
   endtask

   task automatic cs_low();
      if (sel) cs1_n = 1'b0; else cs0_n = 1'b0;
      #HALF;
   endtask

   task automatic cs_high();
      #HALF;
      cs0_n = 1'b1;
      cs1_n = 1'b1;
      #100;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         #HALF sclk = 1'b1;
         #HALF sclk = 1'b0;
      end
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
      send_bits(cmd, 8);
      send_bits(a[23:16], 8);
      send_bits(a[15:8], 8);
      send_bits(a[7:0], 8);
   endtask

   task automatic spi_read(input logic [23:0] a, input int n);
      cs_low();
      send_hdr(8'h03, a);
      for (int i = 0; i < n; i++) send_bits(8'h00, 8);
      cs_high();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0;
      sclk = 1'b0; cs0_n = 1'b1; cs1_n = 1'b1; mosi = 1'b0;
      load_en0 = 1'b0; load_en1 = 1'b0; load_addr = '0; load_data = '0;
      sel = 1'b0;

      repeat (4) @(negedge clk);
      check("rst_miso0", miso0, 1'b0);
      check("rst_oe0", miso_oe0, 1'b0);
      check("rst_busy0", busy0, 1'b0);
      check("rst_miso1", miso1, 1'b0);
      check("rst_oe1", miso_oe1, 1'b0);
      check("rst_busy1", busy1, 1'b0);
      rst0_n = 1'b1; rst1_n = 1'b1;
      repeat (4) @(negedge clk);

      // 1: burst read of preloaded bytes
      preload(8'h10, 8'hDE);
      preload(8'h11, 8'hAD);
      preload(8'h12, 8'hBE);
      preload(8'h13, 8'hEF);
      exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
      exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
      oe_rises = 0;
      cs_low();
      send_bits(8'h03, 8);
      check("cmd_busy", busy0, 1'b1);
      check("cmd_oe", miso_oe0, 1'b0);
      send_bits(8'h00, 8); send_bits(8'h00, 8); send_bits(8'h10, 8);
      send_bits(8'h00, 8);
      check("data_oe", miso_oe0, 1'b1);
      send_bits(8'h00, 8); send_bits(8'h00, 8); send_bits(8'h00, 8);
      cs_high();
      check("oe_rise_count", oe_rises, 32);
      check("end_oe", miso_oe0, 1'b0);
      check("end_busy", busy0, 1'b0);
      check("end_miso", miso0, 1'b0);

      // 2: write two bytes then read them back
      cs_low();
      send_hdr(8'h02, 24'h000020);
      send_bits(8'h11, 8);
      send_bits(8'h22, 8);
      cs_high();
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      spi_read(24'h000020, 2);

      // 3: address wrap and ignored upper address bits
      preload(8'hFF, 8'hA5);
      preload(8'h00, 8'h5A);
      exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
      spi_read(24'h0000FF, 2);
      exp_q.push_back(8'hA5);
      spi_read(24'h1234FF, 1);

      // 4: unknown command is ignored
      oe_rises = 0;
      cs_low();
      send_bits(8'h9F, 8);
      send_bits(8'h00, 8); send_bits(8'h00, 8);
      send_bits(8'h10, 8); send_bits(8'h55, 8);
      check("ign_busy", busy0, 1'b1);
      cs_high();
      check("ign_busy_after", busy0, 1'b0);
      check("ign_oe_rises", oe_rises, 0);
      exp_q.push_back(8'hDE);
      spi_read(24'h000010, 1);

      // 5: partial write byte is discarded
      preload(8'h30, 8'h66);
      cs_low();
      send_hdr(8'h02, 24'h000030);
      send_bits(8'hC3, 3);
      cs_high();
      exp_q.push_back(8'h66);
      spi_read(24'h000030, 1);

      // 6: read-only personality, then reset mid-read
      sel = 1'b1;
      preload(8'h40, 8'h99);
      cs_low();
      send_hdr(8'h02, 24'h000040);
      send_bits(8'h77, 8);
      cs_high();
      exp_q.push_back(8'h99);
      spi_read(24'h000040, 1);

      cs_low();
      send_hdr(8'h03, 24'h000040);
      send_bits(8'h00, 4);
      check("ro_mid_oe", miso_oe1, 1'b1);
      check("ro_mid_busy", busy1, 1'b1);
      @(negedge clk);
      rst1_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_oe", miso_oe1, 1'b0);
      check("rst_mid_busy", busy1, 1'b0);
      @(negedge clk);
      rst1_n = 1'b1;
      send_bits(8'h03, 8);
      send_bits(8'hFF, 8);
      check("post_rst_busy", busy1, 1'b0);
      check("post_rst_oe", miso_oe1, 1'b0);
      cs_high();
      exp_q.push_back(8'h99);
      spi_read(24'h000040, 1);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
